// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: nibble width and default
// timing (clocks per digit slot, anti-ghost blanking clocks).
package disp_scan_ctrl_pkg;

  localparam int unsigned HEX_W         = 4;
  localparam int unsigned DEF_N_DIGITS  = 8;
  localparam int unsigned DEF_SCAN_DIV  = 50000;
  localparam int unsigned DEF_BLANK_CYC = 16;

endpackage

// File: rtl/disp_scan_ctrl_scan_prescaler.sv
// Slot prescaler: free-running 0..SCAN_DIV-1 counter, end-of-slot tick and a
// look-ahead flag telling whether the next clock falls inside the blanking window.
module scan_prescaler
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = DEF_SCAN_DIV,
  parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick,
  output logic o_blank_nxt
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_tick;

  assign w_tick    = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Outputs downstream are registered, so they need the blanking state of the
  // cycle about to start rather than the current one.
  assign o_tick      = w_tick;
  assign o_blank_nxt = (w_cnt_nxt < CW'(BLANK_CYC));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with a
// frame-coherent shadow of the displayed value and leading-zero blanking.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_DIGITS  = DEF_N_DIGITS,
  parameter int unsigned SCAN_DIV  = DEF_SCAN_DIV,
  parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HEX_W*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]       points,
  input  logic [N_DIGITS-1:0]       blank,
  input  logic                      lzb,
  input  logic                      upd_req,
  output logic                      upd_ack,
  output logic                      frame_start,
  output logic [N_DIGITS-1:0]       an,
  output logic [HEX_W-1:0]          hex,
  output logic                      point,
  output logic                      le
);

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DW = HEX_W * N_DIGITS;

  logic                w_tick;
  logic                w_blank_nxt;
  logic                w_wrap;
  logic                w_cap;
  logic [IW-1:0]       w_idx_nxt;

  logic [IW-1:0]       r_idx;
  logic [DW-1:0]       r_shd_data;
  logic [N_DIGITS-1:0] r_shd_pts;
  logic [N_DIGITS-1:0] r_shd_blk;

  logic [DW-1:0]       w_shd_data_nxt;
  logic [N_DIGITS-1:0] w_shd_pts_nxt;
  logic [N_DIGITS-1:0] w_shd_blk_nxt;

  logic                w_zero_run;
  logic [N_DIGITS-1:0] w_lz;
  logic [N_DIGITS-1:0] w_an_nxt;
  logic [HEX_W-1:0]    w_hex_nxt;
  logic                w_point_nxt;
  logic                w_le_nxt;

  logic [N_DIGITS-1:0] r_an;
  logic [HEX_W-1:0]    r_hex;
  logic                r_point;
  logic                r_le;
  logic                r_upd_ack;
  logic                r_frame_start;

  scan_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_tick      (w_tick),
    .o_blank_nxt (w_blank_nxt)
  );

  assign w_wrap    = w_tick && (r_idx == IW'(N_DIGITS - 1));
  assign w_cap     = w_wrap && upd_req;
  assign w_idx_nxt = w_tick ? (w_wrap ? '0 : r_idx + 1'b1) : r_idx;

  // Output registers are loaded from the post-capture shadow so the first slot
  // of a frame already shows freshly captured data.
  assign w_shd_data_nxt = w_cap ? data   : r_shd_data;
  assign w_shd_pts_nxt  = w_cap ? points : r_shd_pts;
  assign w_shd_blk_nxt  = w_cap ? blank  : r_shd_blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_shd_data <= '0;
      r_shd_pts  <= '0;
      r_shd_blk  <= '1;
    end else begin
      r_idx      <= w_idx_nxt;
      r_shd_data <= w_shd_data_nxt;
      r_shd_pts  <= w_shd_pts_nxt;
      r_shd_blk  <= w_shd_blk_nxt;
    end
  end

  // Leading-zero chain walks from the most significant digit downward.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      w_zero_run = w_zero_run & (w_shd_data_nxt[(N_DIGITS-1-k)*HEX_W +: HEX_W] == '0);
      if (k != N_DIGITS - 1) begin
        w_lz[N_DIGITS-1-k] = lzb & w_zero_run;
      end
    end
  end

  always_comb begin
    w_an_nxt = '1;
    if (!w_blank_nxt) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
    w_hex_nxt   = w_shd_data_nxt[w_idx_nxt*HEX_W +: HEX_W];
    w_point_nxt = w_shd_pts_nxt[w_idx_nxt];
    w_le_nxt    = w_shd_blk_nxt[w_idx_nxt] | w_lz[w_idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an          <= '1;
      r_hex         <= '0;
      r_point       <= 1'b0;
      r_le          <= 1'b1;
      r_upd_ack     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an_nxt;
      r_hex         <= w_hex_nxt;
      r_point       <= w_point_nxt;
      r_le          <= w_le_nxt;
      r_upd_ack     <= w_cap;
      r_frame_start <= w_wrap;
    end
  end

  assign an          = r_an;
  assign hex         = r_hex;
  assign point       = r_point;
  assign le          = r_le;
  assign upd_ack     = r_upd_ack;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a driver pushes the expected content of
// each upcoming frame, a monitor checks every cycle of each frame against it.
module tb_disp_scan_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned B  = 1;
  localparam int unsigned FL = N * S;
  localparam int          NF = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  points = '0;
  logic [3:0]  blank = '0;
  logic        lzb = 1'b0;
  logic        upd_req = 1'b0;
  logic        upd_ack, frame_start, point, le;
  logic [3:0]  an, hex;

  disp_scan_ctrl #(
    .N_DIGITS  (N),
    .SCAN_DIV  (S),
    .BLANK_CYC (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .points      (points),
    .blank       (blank),
    .lzb         (lzb),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .frame_start (frame_start),
    .an          (an),
    .hex         (hex),
    .point       (point),
    .le          (le)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
    bit          lz;
    bit          ack;
  } frame_t;

  frame_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sh_d = 16'h0000;
  logic [3:0]  sh_p = 4'h0;
  logic [3:0]  sh_b = 4'hF;

  logic [15:0] t_d[6]   = '{16'h1234, 16'hABCD, 16'hABCD, 16'h0050, 16'h0000, 16'h1234};
  logic [3:0]  t_p[6]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001};
  logic [3:0]  t_b[6]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100};
  bit          t_req[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit          t_lz[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h ({fs,ack,an,hex,pt,le})", name, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {frame_start, upd_ack, an, hex, point, le};
  endfunction

  // Expected outputs at cycle t of a frame, from the display rules directly.
  function automatic logic [11:0] exp_vec(input frame_t e, input int t);
    int          slot;
    int          c;
    logic [3:0]  an_e;
    logic [3:0]  hex_e;
    logic [15:0] above;
    bit          lz_e;
    slot  = t / S;
    c     = t % S;
    an_e  = (c < B) ? 4'hF : ~(4'b0001 << slot);
    above = e.d >> (4 * slot);
    hex_e = above[3:0];
    lz_e  = e.lz && (slot != 0) && (above == 16'h0000);
    return {(t == 0), (t == 0) && e.ack, an_e, hex_e, e.p[slot], e.b[slot] | lz_e};
  endfunction

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic driver();
    logic [15:0] fd;
    logic [3:0]  fp, fb;
    bit          freq, flz, nxt_lz, ok;
    nxt_lz = 1'b0;
    for (int k = 1; k <= NF; k++) begin
      wait_fs(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL drv_frame_start: got none expected pulse within %0d cycles", 3 * FL);
        break;
      end
      lzb = nxt_lz;
      if (k == NF) break;
      if (k <= 6) begin
        fd = t_d[k-1]; fp = t_p[k-1]; fb = t_b[k-1];
        freq = t_req[k-1]; flz = t_lz[k-1];
      end else begin
        fd   = 16'($urandom) >> (4 * $urandom_range(0, 4));
        fp   = 4'($urandom);
        fb   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        freq = ($urandom_range(0, 3) != 0);
        flz  = 1'($urandom_range(0, 1));
      end
      nxt_lz = flz;
      if (freq) begin
        sh_d = fd; sh_p = fp; sh_b = fb;
      end
      q.push_back('{sh_d, sh_p, sh_b, flz, freq});
      data    = 16'($urandom);
      points  = 4'($urandom);
      blank   = 4'($urandom);
      upd_req = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, FL - 2)) @(negedge clk);
      data = fd; points = fp; blank = fb; upd_req = freq;
    end
  endtask

  task automatic monitor();
    frame_t e;
    bit     ok;
    for (int f = 1; f <= NF; f++) begin
      wait_fs(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon_frame_start: got none expected pulse for frame %0d", f);
        break;
      end
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got empty queue expected entry for frame %0d", f);
        break;
      end
      e = q.pop_front();
      for (int t = 0; t < FL; t++) begin
        if (t > 0) @(negedge clk);
        check($sformatf("frame%0d_t%0d", f, t), outs(), exp_vec(e, t));
      end
    end
  endtask

  initial begin
    q.push_back('{16'h0000, 4'h0, 4'hF, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_async", outs(), 12'b0_0_1111_0000_0_1);
    repeat (2) @(negedge clk);
    check("reset_held", outs(), 12'b0_0_1111_0000_0_1);
    rst_n = 1'b1;
    fork
      driver();
      monitor();
    join
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_midframe", outs(), 12'b0_0_1111_0000_0_1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
